// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin bridge from NUM_HOST hosts to NUM_DEVICE
// base/mask-decoded devices; one transaction in flight, decode/timeout errors.
//
// Ports:
//   clock_i, reset_n_i            clock, async active-low reset
//   host_rw_address_i/_write_data_i/_write_strobe_i
//                                 per-host request payload (32/32/4 bits each)
//   host_read_request_i/_write_request_i
//                                 per-host level requests, held until response
//   host_read_data_o              per-host read data, valid with read response
//   host_read_response_o/_write_response_o
//                                 per-host 1-cycle completion pulses
//   host_error_o                  per-host error flag, valid with response
//   device_rw_address_o/_write_data_o/_write_strobe_o
//                                 registered payload, broadcast to all devices
//   device_read_request_o/_write_request_o
//                                 1-cycle pulse to the selected device
//   device_read_data_i/_read_response_i/_write_response_i
//                                 per-device read data and done pulses
//   addr_base, addr_mask          static per-device decode window
module sys_bus_arbiter #(
    parameter int NUM_HOST       = 2,
    parameter int NUM_DEVICE     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic [NUM_HOST*32-1:0]   host_rw_address_i,
    input  logic [NUM_HOST*32-1:0]   host_write_data_i,
    input  logic [NUM_HOST*4-1:0]    host_write_strobe_i,
    input  logic [NUM_HOST-1:0]      host_read_request_i,
    input  logic [NUM_HOST-1:0]      host_write_request_i,
    output logic [NUM_HOST*32-1:0]   host_read_data_o,
    output logic [NUM_HOST-1:0]      host_read_response_o,
    output logic [NUM_HOST-1:0]      host_write_response_o,
    output logic [NUM_HOST-1:0]      host_error_o,
    output logic [NUM_DEVICE*32-1:0] device_rw_address_o,
    output logic [NUM_DEVICE*32-1:0] device_write_data_o,
    output logic [NUM_DEVICE*4-1:0]  device_write_strobe_o,
    output logic [NUM_DEVICE-1:0]    device_read_request_o,
    output logic [NUM_DEVICE-1:0]    device_write_request_o,
    input  logic [NUM_DEVICE*32-1:0] device_read_data_i,
    input  logic [NUM_DEVICE-1:0]    device_read_response_i,
    input  logic [NUM_DEVICE-1:0]    device_write_response_i,
    input  logic [NUM_DEVICE*32-1:0] addr_base,
    input  logic [NUM_DEVICE*32-1:0] addr_mask
);

    localparam int HW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1;
    localparam int DW = (NUM_DEVICE > 1) ? $clog2(NUM_DEVICE) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [HW-1:0] LAST_HOST = HW'(NUM_HOST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [HW-1:0]           last_q, last_d;
    logic [HW-1:0]           gnt_q, gnt_d;
    logic [DW-1:0]           sel_q, sel_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              strb_q, strb_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DEVICE-1:0]   dreq_rd_q, dreq_rd_d;
    logic [NUM_DEVICE-1:0]   dreq_wr_q, dreq_wr_d;
    logic [NUM_HOST-1:0]     hresp_rd_q, hresp_rd_d;
    logic [NUM_HOST-1:0]     hresp_wr_q, hresp_wr_d;
    logic [NUM_HOST-1:0]     herr_q, herr_d;
    logic [NUM_HOST*32-1:0]  hdata_q, hdata_d;

    logic [NUM_HOST-1:0]     host_req;
    logic                    any_req;
    logic [HW-1:0]           pick;
    logic [31:0]             g_addr;
    logic                    g_rd;
    logic                    g_wr;
    logic                    hit;
    logic [DW-1:0]           dsel;

    assign host_req = host_read_request_i | host_write_request_i;

    // First requester after the previous grant, wrapping around.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        for (int i = 0; i < NUM_HOST; i++) begin
            if (!any_req && host_req[(int'(last_q) + 1 + i) % NUM_HOST]) begin
                any_req = 1'b1;
                pick    = HW'((int'(last_q) + 1 + i) % NUM_HOST);
            end
        end
    end

    assign g_addr = host_rw_address_i[int'(pick)*32 +: 32];
    assign g_rd   = host_read_request_i[pick];
    assign g_wr   = host_write_request_i[pick];

    // Descending scan so the lowest matching index is left selected.
    always_comb begin
        hit  = 1'b0;
        dsel = '0;
        for (int j = NUM_DEVICE - 1; j >= 0; j--) begin
            if ((g_addr & addr_mask[j*32 +: 32]) == addr_base[j*32 +: 32]) begin
                hit  = 1'b1;
                dsel = DW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        cnt_d      = cnt_q;
        dreq_rd_d  = '0;
        dreq_wr_d  = '0;
        hresp_rd_d = '0;
        hresp_wr_d = '0;
        herr_d     = '0;
        hdata_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    sel_d   = dsel;
                    rd_d    = g_rd;
                    wr_d    = g_wr;
                    addr_d  = g_addr;
                    wdata_d = host_write_data_i[int'(pick)*32 +: 32];
                    strb_d  = host_write_strobe_i[int'(pick)*4 +: 4];
                    if (!hit || (g_rd && g_wr)) begin
                        hresp_rd_d[pick] = g_rd;
                        hresp_wr_d[pick] = g_wr;
                        herr_d[pick]     = 1'b1;
                        state_d          = S_RESP;
                    end else begin
                        dreq_rd_d[dsel] = g_rd;
                        dreq_wr_d[dsel] = g_wr;
                        state_d         = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response landing with the timeout takes precedence.
                if (rd_q && device_read_response_i[sel_q]) begin
                    hresp_rd_d[gnt_q] = 1'b1;
                    hdata_d[int'(gnt_q)*32 +: 32] =
                        device_read_data_i[int'(sel_q)*32 +: 32];
                    state_d = S_RESP;
                end else if (wr_q && device_write_response_i[sel_q]) begin
                    hresp_wr_d[gnt_q] = 1'b1;
                    state_d           = S_RESP;
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (cnt_q == TO_LAST) begin
                        hresp_rd_d[gnt_q] = rd_q;
                        hresp_wr_d[gnt_q] = wr_q;
                        herr_d[gnt_q]     = 1'b1;
                        state_d           = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_HOST;
            gnt_q      <= '0;
            sel_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            cnt_q      <= '0;
            dreq_rd_q  <= '0;
            dreq_wr_q  <= '0;
            hresp_rd_q <= '0;
            hresp_wr_q <= '0;
            herr_q     <= '0;
            hdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            cnt_q      <= cnt_d;
            dreq_rd_q  <= dreq_rd_d;
            dreq_wr_q  <= dreq_wr_d;
            hresp_rd_q <= hresp_rd_d;
            hresp_wr_q <= hresp_wr_d;
            herr_q     <= herr_d;
            hdata_q    <= hdata_d;
        end
    end

    assign host_read_data_o       = hdata_q;
    assign host_read_response_o   = hresp_rd_q;
    assign host_write_response_o  = hresp_wr_q;
    assign host_error_o           = herr_q;
    assign device_rw_address_o    = {NUM_DEVICE{addr_q}};
    assign device_write_data_o    = {NUM_DEVICE{wdata_q}};
    assign device_write_strobe_o  = {NUM_DEVICE{strb_q}};
    assign device_read_request_o  = dreq_rd_q;
    assign device_write_request_o = dreq_wr_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed checks of sys_bus_arbiter.
// Behavioural devices with per-device response delay; hosts via one task.
module tb_sys_bus_arbiter;

    localparam int NH = 2;
    localparam int ND = 3;

    logic              clock_i = 1'b0;
    logic              reset_n_i;
    logic [NH*32-1:0]  host_rw_address;
    logic [NH*32-1:0]  host_write_data;
    logic [NH*4-1:0]   host_write_strobe;
    logic [NH-1:0]     host_read_request;
    logic [NH-1:0]     host_write_request;
    logic [NH*32-1:0]  host_read_data_o;
    logic [NH-1:0]     host_read_response_o;
    logic [NH-1:0]     host_write_response_o;
    logic [NH-1:0]     host_error_o;
    logic [ND*32-1:0]  device_rw_address_o;
    logic [ND*32-1:0]  device_write_data_o;
    logic [ND*4-1:0]   device_write_strobe_o;
    logic [ND-1:0]     device_read_request_o;
    logic [ND-1:0]     device_write_request_o;
    logic [ND*32-1:0]  dev_rdata;
    logic [ND-1:0]     dev_rresp = '0;
    logic [ND-1:0]     dev_wresp = '0;
    logic [ND*32-1:0]  base;
    logic [ND*32-1:0]  mask;

    assign dev_rdata = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_C0DE};
    assign base      = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    assign mask      = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    sys_bus_arbiter #(
        .NUM_HOST      (NH),
        .NUM_DEVICE    (ND),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock_i                (clock_i),
        .reset_n_i              (reset_n_i),
        .host_rw_address_i      (host_rw_address),
        .host_write_data_i      (host_write_data),
        .host_write_strobe_i    (host_write_strobe),
        .host_read_request_i    (host_read_request),
        .host_write_request_i   (host_write_request),
        .host_read_data_o       (host_read_data_o),
        .host_read_response_o   (host_read_response_o),
        .host_write_response_o  (host_write_response_o),
        .host_error_o           (host_error_o),
        .device_rw_address_o    (device_rw_address_o),
        .device_write_data_o    (device_write_data_o),
        .device_write_strobe_o  (device_write_strobe_o),
        .device_read_request_o  (device_read_request_o),
        .device_write_request_o (device_write_request_o),
        .device_read_data_i     (dev_rdata),
        .device_read_response_i (dev_rresp),
        .device_write_response_i(dev_wresp),
        .addr_base              (base),
        .addr_mask              (mask)
    );

    always #5 clock_i = ~clock_i;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Device model: dly < 0 never responds; otherwise the done pulse
    // comes dly cycles after the cycle following the request pulse.
    int          dly     [ND];
    bit          pend    [ND];
    bit          pend_rd [ND];
    int          wcnt    [ND];
    int          q_dev   [$];
    logic [31:0] q_addr  [$];
    logic [31:0] q_data  [$];
    logic [31:0] q_strb  [$];

    always @(negedge clock_i) begin : dev_model
        logic [ND-1:0] rr;
        logic [ND-1:0] ww;
        rr = '0;
        ww = '0;
        for (int d = 0; d < ND; d++) begin
            if (pend[d]) begin
                if (wcnt[d] == 0) begin
                    if (pend_rd[d]) rr[d] = 1'b1;
                    else ww[d] = 1'b1;
                    pend[d] = 1'b0;
                end else begin
                    wcnt[d]--;
                end
            end
            if (device_read_request_o[d] || device_write_request_o[d]) begin
                q_dev.push_back(d);
                q_addr.push_back(device_rw_address_o[d*32 +: 32]);
                q_data.push_back(device_write_data_o[d*32 +: 32]);
                q_strb.push_back(32'(device_write_strobe_o[d*4 +: 4]));
                if (dly[d] >= 0) begin
                    pend[d]    = 1'b1;
                    pend_rd[d] = device_read_request_o[d];
                    wcnt[d]    = dly[d];
                end
            end
        end
        dev_rresp <= rr;
        dev_wresp <= ww;
    end

    // One host transaction; lat counts cycles from request to response,
    // plat the cycle any device pulse was seen (-1 if none).
    task automatic txn(input int h, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int plat);
        bit done;
        @(negedge clock_i);
        host_rw_address[h*32 +: 32] = a;
        host_write_data[h*32 +: 32] = wd;
        host_write_strobe[h*4 +: 4] = s;
        host_read_request[h]        = rd;
        host_write_request[h]       = wr;
        lat   = 0;
        plat  = -1;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clock_i);
            lat++;
            if (plat < 0 && (|device_read_request_o || |device_write_request_o))
                plat = lat;
            if (host_read_response_o[h] || host_write_response_o[h]) begin
                done  = 1'b1;
                rdata = host_read_data_o[h*32 +: 32];
                err   = host_error_o[h];
            end
        end
        host_read_request[h]  = 1'b0;
        host_write_request[h] = 1'b0;
        if (!done) check("txn_bound", 32'(done), 32'd1);
    endtask

    logic [31:0] rdat;
    logic        err;
    int          lat;
    int          plat;
    int          n0;

    initial begin
        reset_n_i          = 1'b0;
        host_rw_address    = '0;
        host_write_data    = '0;
        host_write_strobe  = '0;
        host_read_request  = '0;
        host_write_request = '0;
        dly                = '{0, 0, 0};
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check("rst_hresp", 32'(host_read_response_o | host_write_response_o), 0);
        check("rst_herr", 32'(host_error_o), 0);
        check("rst_dreq", 32'(device_read_request_o | device_write_request_o), 0);
        check("rst_daddr", device_rw_address_o[31:0], 0);
        reset_n_i = 1'b1;

        // H0 read of dev1, zero-wait device
        txn(0, 1, 0, 32'h1000_0000, 0, 0, rdat, err, lat, plat);
        check("t1_data", rdat, 32'hDEAD_BEEF);
        check("t1_err", 32'(err), 0);
        check("t1_lat", 32'(lat), 3);
        check("t1_plat", 32'(plat), 1);
        check("t1_dev", 32'(q_dev[$]), 1);

        // H1 read of unmapped address
        n0 = q_dev.size();
        txn(1, 1, 0, 32'hFFFF_0000, 0, 0, rdat, err, lat, plat);
        check("t3_err", 32'(err), 1);
        check("t3_data", rdat, 0);
        check("t3_lat", 32'(lat), 1);
        check("t3_plat", 32'(plat), 32'hFFFF_FFFF);
        check("t3_npulse", 32'(q_dev.size()), 32'(n0));

        // both hosts writing back to back: grants must alternate
        n0 = q_dev.size();
        fork
            begin
                logic [31:0] r0; logic e0; int l0; int p0;
                for (int k = 0; k < 2; k++) begin
                    txn(0, 0, 1, 32'(k * 4), 32'hA000_0000 | 32'(k),
                        4'h3, r0, e0, l0, p0);
                    check("t2_h0_err", 32'(e0), 0);
                end
            end
            begin
                logic [31:0] r1; logic e1; int l1; int p1;
                for (int k = 0; k < 2; k++) begin
                    txn(1, 0, 1, 32'(256 + k * 4), 32'hA000_0100 | 32'(k),
                        4'hC, r1, e1, l1, p1);
                    check("t2_h1_err", 32'(e1), 0);
                end
            end
        join
        check("t2_npulse", 32'(q_dev.size() - n0), 4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < q_dev.size()) begin
                check("t2_dev", 32'(q_dev[n0+i]), 0);
                check("t2_addr", q_addr[n0+i], 32'((i % 2) * 256 + (i / 2) * 4));
                check("t2_data", q_data[n0+i],
                      32'hA000_0000 | 32'((i % 2) * 256 + i / 2));
                check("t2_strb", q_strb[n0+i], (i % 2 == 1) ? 32'hC : 32'h3);
            end
        end

        // read and write together is illegal
        n0 = q_dev.size();
        txn(0, 1, 1, 32'h0000_0010, 32'h55, 4'hF, rdat, err, lat, plat);
        check("t5_err", 32'(err), 1);
        check("t5_lat", 32'(lat), 1);
        check("t5_npulse", 32'(q_dev.size()), 32'(n0));

        // overlapping windows: dev1 beats dev2, dev2 alone otherwise
        txn(0, 1, 0, 32'h1000_0040, 0, 0, rdat, err, lat, plat);
        check("t5_ovl_dev", 32'(q_dev[$]), 1);
        check("t5_ovl_data", rdat, 32'hDEAD_BEEF);
        txn(0, 1, 0, 32'h1234_0000, 0, 0, rdat, err, lat, plat);
        check("t5_d2_dev", 32'(q_dev[$]), 2);
        check("t5_d2_data", rdat, 32'h2222_2222);

        // timeout after 4 WAIT cycles
        dly[2] = -1;
        txn(1, 1, 0, 32'h1234_0000, 0, 0, rdat, err, lat, plat);
        check("t4_to_err", 32'(err), 1);
        check("t4_to_lat", 32'(lat), 6);
        check("t4_to_data", rdat, 0);
        check("t4_to_plat", 32'(plat), 1);
        // response on the 4th WAIT cycle wins over the timeout
        dly[2] = 3;
        txn(1, 1, 0, 32'h1234_0000, 0, 0, rdat, err, lat, plat);
        check("t4_edge_err", 32'(err), 0);
        check("t4_edge_lat", 32'(lat), 6);
        check("t4_edge_data", rdat, 32'h2222_2222);

        // asynchronous reset while in WAIT
        dly[1] = -1;
        @(negedge clock_i);
        host_rw_address[31:0] = 32'h1000_0000;
        host_read_request[0]  = 1'b1;
        repeat (2) @(negedge clock_i);
        check("t6_pre_addr", device_rw_address_o[63:32], 32'h1000_0000);
        reset_n_i = 1'b0;
        #1;
        check("t6_daddr", device_rw_address_o[31:0] | device_rw_address_o[63:32]
              | device_rw_address_o[95:64], 0);
        check("t6_dreq", 32'(device_read_request_o | device_write_request_o), 0);
        check("t6_hout", 32'(host_read_response_o | host_write_response_o
              | host_error_o), 0);
        host_read_request[0] = 1'b0;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        dly[1]    = 0;
        txn(0, 1, 0, 32'h1000_0000, 0, 0, rdat, err, lat, plat);
        check("t6_data", rdat, 32'hDEAD_BEEF);
        check("t6_err", 32'(err), 0);
        check("t6_lat", 32'(lat), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
